// File: rtl/state_dumper.sv
// Streams a snapshot of the core's register file and a data-memory window out of a
// valid/ready byte port once the core raises done. Optional trailing checksum: STATE_DUMPER_CHECKSUM_EN.
module state_dumper #(
    parameter int NUM_REGS = 8,
    parameter int DM_LO    = 0,
    parameter int DM_HI    = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       done,
    output logic [2:0] rf_addr,
    input  logic [7:0] rf_data,
    output logic [7:0] dm_addr,
    input  logic [7:0] dm_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       dump_done,
    output logic [2:0] dbg_state
);

    // Handshake: a byte transfers on a rising edge where out_valid and out_ready are both
    // high; while out_valid=1 and out_ready=0, out_data/out_last/out_valid hold steady.

    localparam int NDATA = NUM_REGS + DM_HI - DM_LO + 1;
    localparam int IW    = $clog2(NDATA + 1);
    localparam logic [IW-1:0] NREG_I   = IW'(NUM_REGS);
    localparam logic [IW-1:0] LAST_I   = IW'(NDATA);
    localparam logic [IW-1:0] LASTM1_I = IW'(NDATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        REGS,
        MEM,
`ifdef STATE_DUMPER_CHECKSUM_EN
        CSUM,
`endif
        FIN
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0]    out_data_n;
    logic          out_valid_n, out_last_n, busy_n, dump_done_n;
    logic          done_q;
    logic          trigger, hs;
    logic [7:0]    nxt_byte;
`ifdef STATE_DUMPER_CHECKSUM_EN
    logic [7:0]    csum, csum_n;
`endif

    assign trigger   = done & ~done_q;
    assign hs        = out_valid & out_ready;
    assign dbg_state = state;

    // idx is the global position of the next byte to load: registers first, then memory.
    always_comb begin
        rf_addr  = '0;
        dm_addr  = 8'(DM_LO);
        if (idx < NREG_I) rf_addr = 3'(idx);
        else              dm_addr = 8'(DM_LO) + 8'(idx - NREG_I);
        nxt_byte = (idx < NREG_I) ? rf_data : dm_data;
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        busy_n      = busy;
        dump_done_n = 1'b0;
`ifdef STATE_DUMPER_CHECKSUM_EN
        csum_n      = csum;
`endif
        case (state)
            IDLE: begin
                if (trigger) begin
                    out_data_n  = rf_data;
                    out_valid_n = 1'b1;
                    out_last_n  = 1'b0;
                    busy_n      = 1'b1;
                    idx_n       = IW'(1);
                    state_n     = REGS;
`ifdef STATE_DUMPER_CHECKSUM_EN
                    csum_n      = 8'h00;
`endif
                end
            end
            REGS, MEM: begin
                if (hs) begin
`ifdef STATE_DUMPER_CHECKSUM_EN
                    csum_n = csum + out_data;
`endif
                    if (idx == LAST_I) begin
`ifdef STATE_DUMPER_CHECKSUM_EN
                        out_data_n = csum + out_data;
                        out_last_n = 1'b1;
                        state_n    = CSUM;
`else
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        dump_done_n = 1'b1;
                        state_n     = FIN;
`endif
                    end else begin
                        out_data_n = nxt_byte;
                        idx_n      = idx + IW'(1);
`ifdef STATE_DUMPER_CHECKSUM_EN
                        out_last_n = 1'b0;
`else
                        out_last_n = (idx == LASTM1_I);
`endif
                        // The region of the byte now presented selects the state.
                        state_n    = (idx >= NREG_I) ? MEM : REGS;
                    end
                end
            end
`ifdef STATE_DUMPER_CHECKSUM_EN
            CSUM: begin
                if (hs) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    dump_done_n = 1'b1;
                    state_n     = FIN;
                end
            end
`endif
            FIN: begin
                busy_n  = 1'b0;
                idx_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
            done_q    <= 1'b0;
`ifdef STATE_DUMPER_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            busy      <= busy_n;
            dump_done <= dump_done_n;
            done_q    <= done;
`ifdef STATE_DUMPER_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

endmodule
